bagging_vote_accum: RTL and testbench
=====================================

# bagging_vote_accum

Sequential weighted-vote accumulator for the bagging ensemble classifier: per beat it adds `vote × weight` into a signed accumulator, and after the last learner of an ensemble it emits the total and a signed threshold decision. It is the parametrised successor to the fixed 9-bit, 2-bit-vote multiply-add and sign-compare datapath. It adds over that datapath:
- generic widths and a learner count;
- valid/ready handshakes on input and output;
- optional saturation;
- an ensemble-length guard.

## Interface
Parameters:
- `W_W`, 9, signed weight width.
- `ACC_W`, 12, signed accumulator width; must satisfy `ACC_W >= W_W+2`.
- `MAX_LEARNERS`, 8, maximum beats per ensemble.
- `THRESH`, 0, signed decision threshold (`ACC_W` bits).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_vote`  in  2  signed vote: +1, 0, -1 or -2.
- `in_weight`  in  `W_W`  signed learner weight.
- `in_last`  in  1  final beat of the ensemble.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  `ACC_W`  signed ensemble total.
- `out_class`  out  1  0 if `out_sum < THRESH` (signed), else 1.
- `out_cnt`  out  `$clog2(MAX_LEARNERS+1)`  beats accumulated.
- `out_sat`  out  1  the accumulator clamped at least once during the ensemble.
- `out_err`  out  1  ensemble was force-terminated at `MAX_LEARNERS`.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Product is `$signed(in_vote) * $signed(in_weight)`, `W_W+2` bits, sign-extended to `ACC_W+1` bits. It is added to `acc`, then wrapped or clamped (see Configuration).
- FSM states: `IDLE` (acc=0, cnt=0), `ACCUM`, `HOLD`.
  - `IDLE` on an accepted non-last beat goes to `ACCUM`.
  - `IDLE` or `ACCUM` on an accepted beat with `in_last` goes to `HOLD`.
  - `IDLE` or `ACCUM` on an accepted beat that makes cnt==`MAX_LEARNERS` goes to `HOLD` with `out_err`=1. The beat is treated as last even if `in_last`=0.
  - `HOLD` with `out_ready` clears acc, cnt, sat and err. It goes to `IDLE`, or loads the new beat directly into acc if one is accepted in the same cycle (next state `ACCUM`/`HOLD` as above).
- `in_ready` = `!out_valid || out_ready`. Input and output may handshake in the same cycle.
- `out_valid` is 1 exactly in `HOLD`. `out_sum`, `out_class`, `out_cnt`, `out_sat` and `out_err` are registered and stable while `out_valid && !out_ready`.
- `out_class` is computed from the final acc value, registered with it.
- Reset (any state, including mid-ensemble) gives: state `IDLE`, acc=0, cnt=0, `out_valid`=0, `out_sum`=0, `out_class`=0, `out_cnt`=0, `out_sat`=0, `out_err`=0, `in_ready`=1. A partially accumulated ensemble is discarded.

## Timing
- Accumulate: one beat per cycle, no bubbles; acc is updated the cycle after acceptance.
- Latency: last beat accepted at edge t gives `out_valid`=1 from edge t+1.
- Result is held indefinitely under backpressure; the input is stalled (`in_ready`=0) meanwhile.
- Throughput: a 1-beat ensemble every cycle when `out_ready`=1 is held high.

## Configuration
- `BAGGING_VOTE_SAT_EN` defined: sums outside [-2^(ACC_W-1), 2^(ACC_W-1)-1] clamp to the nearest bound, and `out_sat` becomes sticky 1 for that ensemble.
- `BAGGING_VOTE_SAT_EN` undefined: sums wrap modulo 2^ACC_W, and `out_sat` is tied to 0.

## Structure
- `bagging_pkg` holds:
  - the state enum `vote_state_e`;
  - vote encodings `VOTE_POS`=2'b01, `VOTE_ZERO`=2'b00, `VOTE_NEG`=2'b11, `VOTE_NEG2`=2'b10.
- Sub-module `bagging_mac`: combinational signed multiply-add with optional clamp. It is parametrised on `W_W`/`ACC_W` and outputs the next acc and a sat flag.
- Top level holds the FSM, counter, registers and handshake logic.

## Test plan
All scenarios use default parameters.
- Reset: hold `rst_n`=0 for 2 cycles with random inputs. Required: all outputs 0, `in_ready`=1.
- Basic ensemble: beats (+1,100), (-1,30), (+1,-20,last) back-to-back. Required: `out_valid` one cycle after the last beat, `out_sum`=50, `out_class`=1, `out_cnt`=3, `out_err`=0.
- Saturation: 4 beats of (-2,-256), the 4th with last.
  - With `BAGGING_VOTE_SAT_EN`: `out_sum`=2047, `out_sat`=1, `out_class`=1.
  - Without it: `out_sum`=-2048, `out_class`=0.
- Backpressure: result pending with `out_ready`=0 for 5 cycles. Required: outputs stable and `in_ready`=0. Then `out_ready`=1 together with beat (+1,7,last). Required: that beat is accepted, and the next result is `out_sum`=7, `out_cnt`=1 one cycle later.
- Length guard: 8 beats of (+1,1) with `in_last`=0. Required: `out_valid` after the 8th beat, `out_sum`=8, `out_cnt`=8, `out_err`=1.
- Reset mid-ensemble: 2 beats of (+1,50), then `rst_n`=0 for 1 cycle, then (-1,10,last). Required: `out_sum`=-10, `out_class`=0, `out_cnt`=1.

Source files
------------

// File: rtl/bagging_pkg.sv
// Shared types and vote encodings for the bagging weighted-vote accumulator.
package bagging_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } vote_state_e;

  localparam logic [1:0] VOTE_POS  = 2'b01;
  localparam logic [1:0] VOTE_ZERO = 2'b00;
  localparam logic [1:0] VOTE_NEG  = 2'b11;
  localparam logic [1:0] VOTE_NEG2 = 2'b10;

endpackage

// File: rtl/bagging_mac.sv
// Combinational signed vote*weight multiply-add into the accumulator.
// BAGGING_VOTE_SAT_EN selects clamping on overflow; otherwise the sum wraps.
module bagging_mac #(
  parameter int W_W   = 9,
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [1:0]       vote,
  input  logic [W_W-1:0]   weight,
  output logic [ACC_W-1:0] acc_nxt,
  output logic             sat
);

  logic signed [W_W+1:0] vote_x, weight_x, prod;

  always_comb begin
    vote_x   = {{W_W{vote[1]}}, vote};
    weight_x = {{2{weight[W_W-1]}}, weight};
    prod     = vote_x * weight_x;
  end

`ifdef BAGGING_VOTE_SAT_EN
  logic [ACC_W:0] sum;
  logic           ovf;

  always_comb begin
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-W_W-1){prod[W_W+1]}}, prod};
    // one guard bit: overflow whenever it disagrees with the result sign
    ovf = sum[ACC_W] ^ sum[ACC_W-1];
    sat = ovf;
    if (!ovf)
      acc_nxt = sum[ACC_W-1:0];
    else if (sum[ACC_W])
      acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
    else
      acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  always_comb begin
    sat     = 1'b0;
    acc_nxt = acc + {{(ACC_W-W_W-2){prod[W_W+1]}}, prod};
  end
`endif

endmodule

// File: rtl/bagging_vote_accum.sv
// Weighted-vote accumulator: sums vote*weight per ensemble, emits total + class.
// Optional clamping via BAGGING_VOTE_SAT_EN (default build wraps).
module bagging_vote_accum
  import bagging_pkg::*;
#(
  parameter int                      W_W          = 9,
  parameter int                      ACC_W        = 12,
  parameter int                      MAX_LEARNERS = 8,
  parameter logic signed [ACC_W-1:0] THRESH       = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [1:0]                            in_vote,
  input  logic [W_W-1:0]                        in_weight,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ACC_W-1:0]                      out_sum,
  output logic                                  out_class,
  output logic [$clog2(MAX_LEARNERS+1)-1:0]     out_cnt,
  output logic                                  out_sat,
  output logic                                  out_err
);

  localparam int CNT_W = $clog2(MAX_LEARNERS+1);

  vote_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_base, mac_acc;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_nxt;
  logic             sat_q, sat_base, mac_sat;
  logic             accept, pop, guard, fin;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Only ACCUM carries a running total; IDLE and a draining HOLD start from zero.
  assign acc_base = (state_q == ACCUM) ? acc_q : '0;
  assign cnt_base = (state_q == ACCUM) ? cnt_q : '0;
  assign sat_base = (state_q == ACCUM) ? sat_q : 1'b0;
  assign cnt_nxt  = cnt_base + CNT_W'(1);
  assign guard    = (cnt_nxt == CNT_W'(MAX_LEARNERS));
  assign fin      = accept && (in_last || guard);

  bagging_mac #(.W_W(W_W), .ACC_W(ACC_W)) u_mac (
    .acc     (acc_base),
    .vote    (in_vote),
    .weight  (in_weight),
    .acc_nxt (mac_acc),
    .sat     (mac_sat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = fin ? HOLD : ACCUM;
      HOLD: begin
        if (accept)         state_d = fin ? HOLD : ACCUM;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_sum   <= '0;
      out_class <= 1'b0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= mac_acc;
        cnt_q <= cnt_nxt;
        sat_q <= sat_base | mac_sat;
      end else if (pop) begin
        acc_q <= '0;
        cnt_q <= '0;
        sat_q <= 1'b0;
      end
      if (fin) begin
        out_sum   <= mac_acc;
        out_class <= !($signed(mac_acc) < THRESH);
        out_cnt   <= cnt_nxt;
        out_sat   <= sat_base | mac_sat;
        // a beat that is both last and the length limit is a normal finish
        out_err   <= guard && !in_last;
      end else if (pop) begin
        out_sum   <= '0;
        out_class <= 1'b0;
        out_cnt   <= '0;
        out_sat   <= 1'b0;
        out_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bagging_vote_accum.sv
// Self-checking bench: directed scenarios plus random traffic against an ensemble-level model.
module tb_bagging_vote_accum;
  import bagging_pkg::*;

  localparam int W_W   = 9;
  localparam int ACC_W = 12;
  localparam int MAXL  = 8;
  localparam int CNT_W = 4;
  localparam int AMAX  = 2**(ACC_W-1) - 1;
  localparam int AMIN  = -(2**(ACC_W-1));
`ifdef BAGGING_VOTE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [1:0]       in_vote;
  logic [W_W-1:0]   in_weight;
  logic             out_valid, out_ready, out_class, out_sat, out_err;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;

  bagging_vote_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vote   (in_vote),
    .in_weight (in_weight),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_class (out_class),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model: products of the open ensemble, plus the pending result
  int q[$];
  bit m_hold;
  int e_sum, e_cnt;
  bit e_cls, e_sat, e_err;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int fix(input int x);
    if (SAT_EN) return (x > AMAX) ? AMAX : (x < AMIN) ? AMIN : x;
    return ((x - AMIN) & (2**ACC_W - 1)) + AMIN;
  endfunction

  task automatic model_finish(input bit last);
    int a, t;
    bit s;
    a = 0;
    s = 1'b0;
    foreach (q[i]) begin
      t = a + q[i];
      a = fix(t);
      if (SAT_EN && a != t) s = 1'b1;
    end
    e_sum  = a;
    e_cnt  = q.size();
    e_cls  = (a >= 0);
    e_sat  = s;
    e_err  = !last;
    m_hold = 1'b1;
    q.delete();
  endtask

  task automatic cyc(input bit v, input logic [1:0] vt, input int wt, input bit l, input bit ordy);
    bit take;
    in_valid  = v;
    in_vote   = vt;
    in_weight = W_W'(wt);
    in_last   = l;
    out_ready = ordy;
    #1;
    chk("in_ready", int'(in_ready), int'(!m_hold || ordy));
    take = v && (!m_hold || ordy);
    @(posedge clk); #1;
    if (m_hold && ordy) m_hold = 1'b0;
    if (take) begin
      q.push_back(int'($signed(vt)) * int'($signed(in_weight)));
      if (l || q.size() == MAXL) model_finish(l);
    end
    chk("out_valid", int'(out_valid), int'(m_hold));
    if (m_hold) begin
      chk("out_sum", int'($signed(out_sum)), e_sum);
      chk("out_class", int'(out_class), int'(e_cls));
      chk("out_cnt", int'(out_cnt), e_cnt);
      chk("out_sat", int'(out_sat), int'(e_sat));
      chk("out_err", int'(out_err), int'(e_err));
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vote   = 2'($urandom_range(0, 3));
      in_weight = W_W'($urandom_range(0, 511));
      in_last   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_cnt", int'(out_cnt), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n  = 1'b1;
    q.delete();
    m_hold = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_vote = '0; in_weight = '0;
    in_last = 1'b0; out_ready = 1'b0; m_hold = 1'b0;
    do_reset(2);

    // basic ensemble -> 50
    cyc(1, VOTE_POS, 100, 0, 1);
    cyc(1, VOTE_NEG, 30, 0, 1);
    cyc(1, VOTE_POS, -20, 1, 1);
    cyc(0, VOTE_ZERO, 0, 0, 1);

    // saturation / wrap: 4 x 512
    for (int i = 0; i < 4; i++) cyc(1, VOTE_NEG2, -256, i == 3, 1);
    cyc(0, VOTE_ZERO, 0, 0, 1);

    // backpressure, then drain + new 1-beat ensemble in the same cycle
    cyc(1, VOTE_POS, 5, 1, 0);
    repeat (5) cyc(1, VOTE_POS, int'($urandom_range(0, 100)), 1, 0);
    cyc(1, VOTE_POS, 7, 1, 1);
    cyc(0, VOTE_ZERO, 0, 0, 1);

    // length guard
    repeat (MAXL) cyc(1, VOTE_POS, 1, 0, 1);
    cyc(0, VOTE_ZERO, 0, 0, 1);

    // reset mid-ensemble discards partial sum
    repeat (2) cyc(1, VOTE_POS, 50, 0, 1);
    do_reset(1);
    cyc(1, VOTE_NEG, 10, 1, 1);
    cyc(0, VOTE_ZERO, 0, 0, 1);

    // 1-beat ensembles back to back
    for (int i = 0; i < 6; i++) cyc(1, VOTE_NEG2, i * 40 - 100, 1, 1);
    cyc(0, VOTE_ZERO, 0, 0, 1);

    // random traffic
    repeat (600)
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          int'($urandom_range(0, 511)) - 256, 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
